// File: rtl/jogo_pkg.sv
// Shared definitions for the game input stage: FSM state codes, default
// sizing constants and a popcount helper for the button vector.
package jogo_pkg;

  localparam int N_BOTOES_PADRAO = 4;
  localparam int DEBOUNCE_PADRAO = 50000;  // 1 ms at 50 MHz
  localparam int CNT_W_PADRAO    = 16;

  // Encodings are visible on db_estado, so they are fixed explicitly.
  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

  // Number of set bits; callers zero-extend their vector to 32 bits.
  function automatic int contar_uns(input logic [31:0] v);
    int total;
    total = 0;
    for (int i = 0; i < 32; i++) begin
      total += int'(v[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a vector of asynchronous button pins.
// Each bit is synchronised independently; the output lags the input by two
// clock edges.
module sincronizador_2ff
  import jogo_pkg::*;
#(
  parameter int W = N_BOTOES_PADRAO
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] dado_i,
  output logic [W-1:0] dado_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sinc_q;

  // First stage may go metastable; the second stage gives it a full cycle to settle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= dado_i;
      sinc_q <= meta_q;
    end
  end

  assign dado_o = sinc_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronises and debounces raw buttons, then emits a
// one-cycle "play made" pulse per accepted press together with the captured
// vector and a sticky multi-button flag.
// Build option: define REJEITA_MULTIPLO_EN to suppress the pulse (and keep the
// previous code) for presses with more than one button down.
module condicionador_botoes
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int CNT_W           = CNT_W_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_raw,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] botoes_limpos,
  output logic                jogada_pulso,
  output logic [N_BOTOES-1:0] jogada_codigo,
  output logic                multiplo,
  output logic [3:0]          db_estado
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] s;
  estado_t             estado_q, estado_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BOTOES-1:0] limpos_q, limpos_d;
  logic [N_BOTOES-1:0] codigo_q, codigo_d;
  logic                pulso_q, pulso_d;
  logic                multiplo_q, multiplo_d;
  logic                estavel;
  logic                varios;

  sincronizador_2ff #(
    .W(N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .dado_i(botoes_raw),
    .dado_o(s)
  );

  assign estavel = (cnt_q == CNT_MAX);
  assign varios  = (contar_uns(32'(cand_q)) > 1);

  // Next state: stability counter, debounce FSM and the press-capture registers.
  always_comb begin
    estado_d   = estado_q;
    cand_d     = cand_q;
    limpos_d   = limpos_q;
    codigo_d   = codigo_q;
    multiplo_d = multiplo_q;
    pulso_d    = 1'b0;
    // Counter measures how long s has matched the candidate; it saturates.
    if (s != cand_q) begin
      cnt_d = '0;
    end else if (!estavel) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (estado_q)
      OCIOSO: begin
        limpos_d = '0;
        if (s != '0) begin
          estado_d = FILTRA_PRESS;
          cand_d   = s;
          cnt_d    = '0;
        end
      end
      FILTRA_PRESS: begin
        if (s == '0) begin
          estado_d = OCIOSO;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = '0;
        end else if (estavel) begin
          estado_d = PRESSIONADO;
          limpos_d = cand_q;
          // With habilita low the press is consumed silently.
          if (habilita) begin
`ifdef REJEITA_MULTIPLO_EN
            if (varios) begin
              multiplo_d = 1'b1;
            end else begin
              pulso_d    = 1'b1;
              codigo_d   = cand_q;
              multiplo_d = 1'b0;
            end
`else
            pulso_d    = 1'b1;
            codigo_d   = cand_q;
            multiplo_d = varios;
`endif
          end
        end
      end
      PRESSIONADO: begin
        // Candidate now tracks the new raw level so its stability can be timed.
        if (s != cand_q) begin
          estado_d = FILTRA_SOLTA;
          cand_d   = s;
          cnt_d    = '0;
        end
      end
      FILTRA_SOLTA: begin
        // limpos_q still holds the accepted vector, used to spot a bounce back.
        if (s == limpos_q) begin
          estado_d = PRESSIONADO;
          cand_d   = s;
          cnt_d    = '0;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = '0;
        end else if (estavel) begin
          if (s == '0) begin
            estado_d = OCIOSO;
            limpos_d = '0;
          end else begin
            estado_d = PRESSIONADO;
            limpos_d = cand_q;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      cand_q     <= '0;
      cnt_q      <= '0;
      limpos_q   <= '0;
      codigo_q   <= '0;
      pulso_q    <= 1'b0;
      multiplo_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      limpos_q   <= limpos_d;
      codigo_q   <= codigo_d;
      pulso_q    <= pulso_d;
      multiplo_q <= multiplo_d;
    end
  end

  assign botoes_limpos = limpos_q;
  assign jogada_pulso  = pulso_q;
  assign jogada_codigo = codigo_q;
  assign multiplo      = multiplo_q;
  assign db_estado     = {2'b00, estado_q};

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CYCLES = 4.
// Tick k = 1 is the clock edge that first samples a raw change; a clean
// press pulses on tick 1 + (2 + DEBOUNCE_CYCLES).
module tb_condicionador_botoes;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] botoes_raw = '0;
  logic          habilita = 1'b1;
  logic [NB-1:0] botoes_limpos;
  logic          jogada_pulso;
  logic [NB-1:0] jogada_codigo;
  logic          multiplo;
  logic [3:0]    db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  condicionador_botoes #(
    .N_BOTOES       (NB),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_raw   (botoes_raw),
    .habilita     (habilita),
    .botoes_limpos(botoes_limpos),
    .jogada_pulso (jogada_pulso),
    .jogada_codigo(jogada_codigo),
    .multiplo     (multiplo),
    .db_estado    (db_estado)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_all();
    botoes_raw = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_tests++; if (botoes_limpos !== 4'b0000) begin n_fail++; $display("FAIL reset_limpos got=%b exp=0000", botoes_limpos); end
    n_tests++; if (jogada_pulso !== 1'b0) begin n_fail++; $display("FAIL reset_pulso got=%b exp=0", jogada_pulso); end
    n_tests++; if (jogada_codigo !== 4'b0000) begin n_fail++; $display("FAIL reset_codigo got=%b exp=0000", jogada_codigo); end
    n_tests++; if (multiplo !== 1'b0) begin n_fail++; $display("FAIL reset_multiplo got=%b exp=0", multiplo); end
    n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
    reset = 1'b1;
    tick();
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_press_basic();
    int pulses = 0;
    int pulse_tick = -1;
    botoes_raw = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_pulso) begin pulses++; pulse_tick = k; end
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL basic_pulse_count got=%0d exp=1", pulses); end
    n_tests++; if (pulse_tick !== LAT + 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", pulse_tick, LAT + 1); end
    n_tests++; if (jogada_codigo !== 4'b0010) begin n_fail++; $display("FAIL basic_codigo got=%b exp=0010", jogada_codigo); end
    n_tests++; if (botoes_limpos !== 4'b0010) begin n_fail++; $display("FAIL basic_limpos got=%b exp=0010", botoes_limpos); end
    n_tests++; if (multiplo !== 1'b0) begin n_fail++; $display("FAIL basic_multiplo got=%b exp=0", multiplo); end
    n_tests++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL basic_estado got=%0d exp=2", db_estado); end
    release_all();
    n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL basic_release_estado got=%0d exp=0", db_estado); end
    n_tests++; if (botoes_limpos !== 4'b0000) begin n_fail++; $display("FAIL basic_release_limpos got=%b exp=0000", botoes_limpos); end
    $display("[TB] press 0010: pulses=%0d at tick %0d codigo=%b", pulses, pulse_tick, jogada_codigo);
  endtask

  task automatic test_glitch();
    int pulses = 0;
    bit saw_fp = 1'b0;
    bit limpos_set = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      botoes_raw = (k <= 2) ? 4'b0001 : 4'b0000;
      tick();
      if (jogada_pulso) pulses++;
      if (botoes_limpos != 4'b0000) limpos_set = 1'b1;
      if (db_estado == 4'd1) saw_fp = 1'b1;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL glitch_pulse got=%0d exp=0", pulses); end
    n_tests++; if (limpos_set !== 1'b0) begin n_fail++; $display("FAIL glitch_limpos got=%b exp=0", limpos_set); end
    n_tests++; if (saw_fp !== 1'b1) begin n_fail++; $display("FAIL glitch_filtra got=%b exp=1", saw_fp); end
    n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL glitch_estado got=%0d exp=0", db_estado); end
    $display("[TB] glitch 0001x2: pulses=%0d estado=%0d", pulses, db_estado);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int pulse_tick = -1;
    // Raw per tick: 1 1 0 1 0 1 then held; last rising sample is tick 6.
    for (int k = 1; k <= 26; k++) begin
      botoes_raw = (k == 3 || k == 5) ? 4'b0000 : 4'b1000;
      tick();
      if (jogada_pulso) begin pulses++; pulse_tick = k; end
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulses); end
    n_tests++; if (pulse_tick !== 6 + LAT) begin n_fail++; $display("FAIL bounce_pulse_tick got=%0d exp=%0d", pulse_tick, 6 + LAT); end
    n_tests++; if (botoes_limpos !== 4'b1000) begin n_fail++; $display("FAIL bounce_limpos_held got=%b exp=1000", botoes_limpos); end
    for (int k = 1; k <= 10; k++) begin
      botoes_raw = 4'b0000;
      tick();
      if (k == LAT) begin
        n_tests++; if (botoes_limpos !== 4'b1000) begin n_fail++; $display("FAIL bounce_release_early got=%b exp=1000", botoes_limpos); end
        n_tests++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL bounce_release_state got=%0d exp=3", db_estado); end
      end
      if (k == LAT + 1) begin
        n_tests++; if (botoes_limpos !== 4'b0000) begin n_fail++; $display("FAIL bounce_release_done got=%b exp=0000", botoes_limpos); end
        n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL bounce_release_idle got=%0d exp=0", db_estado); end
      end
    end
    $display("[TB] bounce 1000: pulses=%0d at tick %0d", pulses, pulse_tick);
  endtask

  task automatic test_multiplo();
    int pulses = 0;
    botoes_raw = 4'b0110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_pulso) pulses++;
    end
    n_tests++; if (botoes_limpos !== 4'b0110) begin n_fail++; $display("FAIL multi_limpos got=%b exp=0110", botoes_limpos); end
    n_tests++; if (multiplo !== 1'b1) begin n_fail++; $display("FAIL multi_flag got=%b exp=1", multiplo); end
`ifdef REJEITA_MULTIPLO_EN
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL multi_pulse got=%0d exp=0", pulses); end
    n_tests++; if (jogada_codigo !== 4'b1000) begin n_fail++; $display("FAIL multi_codigo got=%b exp=1000", jogada_codigo); end
`else
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL multi_pulse got=%0d exp=1", pulses); end
    n_tests++; if (jogada_codigo !== 4'b0110) begin n_fail++; $display("FAIL multi_codigo got=%b exp=0110", jogada_codigo); end
`endif
    release_all();
    $display("[TB] multi 0110: pulses=%0d multiplo=%b codigo=%b", pulses, multiplo, jogada_codigo);
  endtask

  task automatic test_multiplo_clear();
    int pulses = 0;
    botoes_raw = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_pulso) pulses++;
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL clear_pulse got=%0d exp=1", pulses); end
    n_tests++; if (multiplo !== 1'b0) begin n_fail++; $display("FAIL clear_multiplo got=%b exp=0", multiplo); end
    n_tests++; if (jogada_codigo !== 4'b0001) begin n_fail++; $display("FAIL clear_codigo got=%b exp=0001", jogada_codigo); end
    release_all();
    $display("[TB] single 0001 after multi: pulses=%0d multiplo=%b", pulses, multiplo);
  endtask

  task automatic test_habilita();
    int pulses = 0;
    habilita   = 1'b0;
    botoes_raw = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_pulso) pulses++;
    end
    n_tests++; if (botoes_limpos !== 4'b0100) begin n_fail++; $display("FAIL hab_limpos got=%b exp=0100", botoes_limpos); end
    n_tests++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL hab_estado got=%0d exp=2", db_estado); end
    habilita = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_pulso) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL hab_pulse got=%0d exp=0", pulses); end
    n_tests++; if (jogada_codigo !== 4'b0001) begin n_fail++; $display("FAIL hab_codigo got=%b exp=0001", jogada_codigo); end
    n_tests++; if (multiplo !== 1'b0) begin n_fail++; $display("FAIL hab_multiplo got=%b exp=0", multiplo); end
    release_all();
    $display("[TB] habilita=0 press 0100: pulses=%0d codigo=%b", pulses, jogada_codigo);
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    int pulse_tick = -1;
    botoes_raw = 4'b0001;
    repeat (10) tick();
    n_tests++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL rmid_pre_state got=%0d exp=2", db_estado); end
    reset = 1'b0;
    #1;
    n_tests++; if (botoes_limpos !== 4'b0000) begin n_fail++; $display("FAIL rmid_limpos got=%b exp=0000", botoes_limpos); end
    n_tests++; if (jogada_codigo !== 4'b0000) begin n_fail++; $display("FAIL rmid_codigo got=%b exp=0000", jogada_codigo); end
    n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL rmid_estado got=%0d exp=0", db_estado); end
    repeat (3) tick();
    n_tests++; if (jogada_pulso !== 1'b0 || multiplo !== 1'b0) begin n_fail++; $display("FAIL rmid_held got=%b%b exp=00", jogada_pulso, multiplo); end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_pulso) begin pulses++; pulse_tick = k; end
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL rmid_pulse_count got=%0d exp=1", pulses); end
    n_tests++; if (pulse_tick !== LAT + 1) begin n_fail++; $display("FAIL rmid_latency got=%0d exp=%0d", pulse_tick, LAT + 1); end
    n_tests++; if (jogada_codigo !== 4'b0001) begin n_fail++; $display("FAIL rmid_codigo_after got=%b exp=0001", jogada_codigo); end
    release_all();
    $display("[TB] reset mid-press 0001: pulses=%0d at tick %0d", pulses, pulse_tick);
  endtask

  initial begin
    test_reset();
    test_press_basic();
    test_glitch();
    test_bounce();
    test_multiplo();
    test_multiplo_clear();
    test_habilita();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
